// File: rtl/sc_reg_capture.sv
// sc_reg_capture: single-entry capture buffer at the receiving end of a
// register-sourced data bus. A word is taken on a valid/ready handshake and held
// until the consumer acks. The block also flags and counts words that equal a fixed
// pattern, and it records any word that a producer offers while the buffer is full.
//
// Handshake: a word transfers on a posedge where Valid_In=1 and Ready_Out=1.
// Ready_Out is decoded from the state register only, so it never depends
// combinationally on Valid_In. Valid_In must hold its word until that edge.
// A Valid_In=1 on an edge where Ready_Out=0 drops the word and sets the sticky
// overrun flag. Ack_In is only sampled while the buffer is full.
module sc_reg_capture #(
    parameter int                       DATAWIDTH_BUS          = 8,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGCAPTURE_INIT   = 8'b00000000,
    parameter logic [DATAWIDTH_BUS-1:0] DATA_REGCAPTURE_EXPECT = 8'b10100101,
    parameter int                       CNTWIDTH               = 4
) (
    input  logic                     SC_RegCAPTURE_CLOCK_50,
    input  logic                     SC_RegCAPTURE_Reset_InHigh,
    input  logic [DATAWIDTH_BUS-1:0] SC_RegCAPTURE_DataBUS_In,
    input  logic                     SC_RegCAPTURE_Valid_In,
    input  logic                     SC_RegCAPTURE_Ack_In,
    output logic                     SC_RegCAPTURE_Ready_Out,
    output logic                     SC_RegCAPTURE_Full_Out,
    output logic [DATAWIDTH_BUS-1:0] SC_RegCAPTURE_DataBUS_Out,
    output logic                     SC_RegCAPTURE_Match_Out,
    output logic [CNTWIDTH-1:0]      SC_RegCAPTURE_MatchCnt_Out,
    output logic                     SC_RegCAPTURE_Overrun_Out
);

    typedef enum logic {
        stateEmpty = 1'b0,
        stateFull  = 1'b1
    } stateType;

    localparam logic [CNTWIDTH-1:0] cntMax = {CNTWIDTH{1'b1}};
    localparam logic [CNTWIDTH-1:0] cntOne = {{(CNTWIDTH-1){1'b0}}, 1'b1};

    stateType                 stateReg;
    stateType                 stateNext;
    logic [DATAWIDTH_BUS-1:0] dataReg;
    logic                     matchReg;
    logic [CNTWIDTH-1:0]      matchCntReg;
    logic                     overrunReg;
    logic                     captureNow;
    logic                     wordMatches;
    logic                     overrunNow;

    // Qualified events: a capture only happens from EMPTY, and an offer in FULL
    // is an overrun (this includes an offer on the same edge as the ack).
    assign captureNow  = (stateReg == stateEmpty) && SC_RegCAPTURE_Valid_In;
    assign overrunNow  = (stateReg == stateFull) && SC_RegCAPTURE_Valid_In;
    assign wordMatches = (SC_RegCAPTURE_DataBUS_In == DATA_REGCAPTURE_EXPECT);

    // State register; reset overrides everything else on the same edge.
    always_ff @(posedge SC_RegCAPTURE_CLOCK_50) begin
        if (SC_RegCAPTURE_Reset_InHigh) begin
            stateReg <= stateEmpty;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic: fill on valid, drain on ack.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            stateEmpty: if (SC_RegCAPTURE_Valid_In) stateNext = stateFull;
            stateFull:  if (SC_RegCAPTURE_Ack_In)   stateNext = stateEmpty;
            default:    stateNext = stateEmpty;
        endcase
    end

    // Handshake outputs decoded from the state register only.
    always_comb begin
        SC_RegCAPTURE_Ready_Out = 1'b0;
        SC_RegCAPTURE_Full_Out  = 1'b0;
        case (stateReg)
            stateEmpty: SC_RegCAPTURE_Ready_Out = 1'b1;
            stateFull:  SC_RegCAPTURE_Full_Out  = 1'b1;
            default:    SC_RegCAPTURE_Ready_Out = 1'b0;
        endcase
    end

    // Held word and its match flag; the word survives the ack and the flag does not.
    always_ff @(posedge SC_RegCAPTURE_CLOCK_50) begin
        if (SC_RegCAPTURE_Reset_InHigh) begin
            dataReg  <= DATA_REGCAPTURE_INIT;
            matchReg <= 1'b0;
        end else if (captureNow) begin
            dataReg  <= SC_RegCAPTURE_DataBUS_In;
            matchReg <= wordMatches;
        end else if ((stateReg == stateFull) && SC_RegCAPTURE_Ack_In) begin
            matchReg <= 1'b0;
        end
    end

    // Saturating count of matching captures; dropped words are never counted.
    always_ff @(posedge SC_RegCAPTURE_CLOCK_50) begin
        if (SC_RegCAPTURE_Reset_InHigh) begin
            matchCntReg <= '0;
        end else if (captureNow && wordMatches && (matchCntReg != cntMax)) begin
            matchCntReg <= matchCntReg + cntOne;
        end
    end

    // Sticky overrun flag, cleared only by reset.
    always_ff @(posedge SC_RegCAPTURE_CLOCK_50) begin
        if (SC_RegCAPTURE_Reset_InHigh) begin
            overrunReg <= 1'b0;
        end else if (overrunNow) begin
            overrunReg <= 1'b1;
        end
    end

    assign SC_RegCAPTURE_DataBUS_Out  = dataReg;
    assign SC_RegCAPTURE_Match_Out    = matchReg;
    assign SC_RegCAPTURE_MatchCnt_Out = matchCntReg;
    assign SC_RegCAPTURE_Overrun_Out  = overrunReg;

endmodule

// File: tb/tb_sc_reg_capture.sv
// Bench for sc_reg_capture: directed vectors with hand-computed expectations.
// Each issued capture pushes {data, match, count, overrun} into exp_q; a monitor
// pops and compares every time the buffer goes from empty to full. Point checks
// cover reset values, acks, overruns and the reset-during-full case.
module tb_sc_reg_capture;

    logic       clk;
    logic       rst;
    logic [7:0] dataIn;
    logic       validIn;
    logic       ackIn;
    logic       readyOut;
    logic       fullOut;
    logic [7:0] dataOut;
    logic       matchOut;
    logic [3:0] matchCntOut;
    logic       overrunOut;

    int checks;
    int errors;

    // {data[13:6], match[5], count[4:1], overrun[0]}
    logic [13:0] exp_q[$];
    logic        prevFull;

    sc_reg_capture dut (
        .SC_RegCAPTURE_CLOCK_50     (clk),
        .SC_RegCAPTURE_Reset_InHigh (rst),
        .SC_RegCAPTURE_DataBUS_In   (dataIn),
        .SC_RegCAPTURE_Valid_In     (validIn),
        .SC_RegCAPTURE_Ack_In       (ackIn),
        .SC_RegCAPTURE_Ready_Out    (readyOut),
        .SC_RegCAPTURE_Full_Out     (fullOut),
        .SC_RegCAPTURE_DataBUS_Out  (dataOut),
        .SC_RegCAPTURE_Match_Out    (matchOut),
        .SC_RegCAPTURE_MatchCnt_Out (matchCntOut),
        .SC_RegCAPTURE_Overrun_Out  (overrunOut)
    );

    // Clock and initial input levels
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: a new capture is an empty-to-full transition seen on the falling edge.
    initial prevFull = 1'b0;
    always @(negedge clk) begin
        if (fullOut && !prevFull) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL capture_unexpected: got data=%h match=%b cnt=%0d ovr=%b, required no capture",
                         dataOut, matchOut, matchCntOut, overrunOut);
            end else begin
                logic [13:0] e;
                e = exp_q.pop_front();
                if ({dataOut, matchOut, matchCntOut, overrunOut} !== e) begin
                    errors++;
                    $display("FAIL capture: got data=%h match=%b cnt=%0d ovr=%b, required data=%h match=%b cnt=%0d ovr=%b",
                             dataOut, matchOut, matchCntOut, overrunOut,
                             e[13:6], e[5], e[4:1], e[0]);
                end
            end
        end
        prevFull = fullOut;
    end

    // Point check helper
    task automatic chk(input string name, input logic [7:0] actual, input logic [7:0] required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, actual, required);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) tick();
        rst = 1'b0;
    endtask

    // Offer one word while empty and queue what the monitor should see.
    task automatic capture(input logic [7:0] d, input logic m, input logic [3:0] c, input logic o);
        dataIn  = d;
        validIn = 1'b1;
        exp_q.push_back({d, m, c, o});
        tick();
        validIn = 1'b0;
    endtask

    task automatic ack();
        ackIn = 1'b1;
        tick();
        ackIn = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_data"},    dataOut,             8'h00);
        chk({tag, "_ready"},   {7'd0, readyOut},    8'd1);
        chk({tag, "_full"},    {7'd0, fullOut},     8'd0);
        chk({tag, "_match"},   {7'd0, matchOut},    8'd0);
        chk({tag, "_cnt"},     {4'd0, matchCntOut}, 8'd0);
        chk({tag, "_overrun"}, {7'd0, overrunOut},  8'd0);
    endtask

    // Stimulus
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        dataIn  = 8'h00;
        validIn = 1'b0;
        ackIn   = 1'b0;
        #2;

        // Reset values
        do_reset(2);
        chk_reset_values("reset");

        // Plain capture and ack
        capture(8'h3C, 1'b0, 4'd0, 1'b0);
        chk("cap_ready", {7'd0, readyOut}, 8'd0);
        chk("cap_full",  {7'd0, fullOut},  8'd1);
        ack();
        chk("ack_full",  {7'd0, fullOut},  8'd0);
        chk("ack_ready", {7'd0, readyOut}, 8'd1);
        chk("ack_data",  dataOut,          8'h3C);

        // Pattern matches and counter saturation
        capture(8'hA5, 1'b1, 4'd1, 1'b0);
        ack();
        chk("match_cleared", {7'd0, matchOut}, 8'd0);
        for (int i = 2; i <= 17; i++) begin
            capture(8'hA5, 1'b1, (i > 15) ? 4'd15 : 4'(i), 1'b0);
            ack();
        end
        chk("cnt_saturated", {4'd0, matchCntOut}, 8'd15);

        // Overrun while full: word dropped, flag sticky
        capture(8'h11, 1'b0, 4'd15, 1'b0);
        dataIn  = 8'h22;
        validIn = 1'b1;
        tick();
        validIn = 1'b0;
        chk("ovr_data",    dataOut,            8'h11);
        chk("ovr_flag",    {7'd0, overrunOut}, 8'd1);
        chk("ovr_full",    {7'd0, fullOut},    8'd1);
        ack();
        capture(8'h33, 1'b0, 4'd15, 1'b1);
        ack();
        chk("ovr_sticky",  {7'd0, overrunOut}, 8'd1);

        // Ack and valid on the same edge while full
        do_reset(1);
        capture(8'h11, 1'b0, 4'd0, 1'b0);
        dataIn  = 8'h44;
        validIn = 1'b1;
        ackIn   = 1'b1;
        tick();
        validIn = 1'b0;
        ackIn   = 1'b0;
        chk("same_full",    {7'd0, fullOut},     8'd0);
        chk("same_ready",   {7'd0, readyOut},    8'd1);
        chk("same_data",    dataOut,             8'h11);
        chk("same_overrun", {7'd0, overrunOut},  8'd1);
        chk("same_cnt",     {4'd0, matchCntOut}, 8'd0);
        tick();
        chk("same_idle_data", dataOut, 8'h11);

        // Reset while full, with a word offered on the same edge
        capture(8'hA5, 1'b1, 4'd1, 1'b1);
        ack();
        capture(8'hA5, 1'b1, 4'd2, 1'b1);
        ack();
        capture(8'hA5, 1'b1, 4'd3, 1'b1);
        chk("pre_rst_cnt", {4'd0, matchCntOut}, 8'd3);
        rst     = 1'b1;
        dataIn  = 8'h5A;
        validIn = 1'b1;
        tick();
        rst     = 1'b0;
        validIn = 1'b0;
        chk_reset_values("midrst");
        capture(8'hA5, 1'b1, 4'd1, 1'b0);
        ack();
        capture(8'h77, 1'b0, 4'd1, 1'b0);
        ack();

        // Drain: every queued capture must have been seen, within a cycle budget
        for (int w = 0; w < 10 && exp_q.size() != 0; w++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending captures, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
